// File: rtl/pwm_servo_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_servo_decoder
//  Description : Measures the high time of an incoming servo PWM pulse train
//                in prescaler ticks and recovers the 8-bit angle code.
//                Also flags out-of-range pulses and loss of signal.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_servo_decoder #(
  parameter int CNTR_WIDTH  = 11,
  parameter int MIN_TICKS   = 50,
  parameter int MAX_TICKS   = 250,
  parameter int LOST_TICKS  = 4096,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       tick_i,
  input  logic       pwm_in_i,
  output logic [7:0] deg_o,
  output logic       deg_valid_o,
  output logic       pulse_err_o,
  output logic       signal_lost_o
);

  localparam int LOST_W = $clog2(LOST_TICKS + 1);

  localparam logic [CNTR_WIDTH-1:0] MIN_W   = CNTR_WIDTH'(MIN_TICKS);
  localparam logic [CNTR_WIDTH-1:0] MAX_W   = CNTR_WIDTH'(MAX_TICKS);
  localparam logic [CNTR_WIDTH-1:0] SAT_W   = CNTR_WIDTH'(MAX_TICKS + 1);
  localparam logic [CNTR_WIDTH-1:0] ONE_W   = CNTR_WIDTH'(1);
  localparam logic [LOST_W-1:0]     LOST_C  = LOST_W'(LOST_TICKS);
  localparam logic [LOST_W-1:0]     ONE_L   = LOST_W'(1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_HIGH      = 3'd3;
  localparam logic [2:0] ST_CHECK     = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   sync_out;

  logic [2:0]             state_q, state_d;
  logic [CNTR_WIDTH-1:0]  width_q, width_d;
  logic [7:0]             deg_q, deg_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [LOST_W-1:0]      lost_cnt_q, lost_cnt_d;
  logic                   lost_q, lost_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchronizer chain followed by the edge-detect register (registered rise/fall)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in_i};
      level_q <= sync_out;
      rise_q  <= sync_out & ~level_q;
      fall_q  <= ~sync_out & level_q;
    end
  end

  // Measurement FSM, decode, and loss-of-signal next-state logic
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    deg_d      = deg_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    lost_cnt_d = lost_cnt_q;
    lost_d     = lost_q;

    case (state_q)
      ST_IDLE: begin
        if (en_i) state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        // The whole pipeline must read low: right after reset the cleared
        // synchronizer would otherwise fake a low level under a high input.
        if (!level_q && (sync_q == '0)) state_d = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (rise_q) begin
          width_d = tick_i ? ONE_W : '0;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        // The tick that coincides with the fall is deliberately not counted
        if (fall_q) begin
          state_d = ST_CHECK;
        end else if (tick_i && level_q && (width_q != SAT_W)) begin
          width_d = width_q + ONE_W;
        end
      end
      ST_CHECK: begin
        if ((width_q >= MIN_W) && (width_q <= MAX_W)) begin
          deg_d   = 8'(width_q - MIN_W);
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = ST_WAIT_RISE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable wins over everything: drop the in-flight measurement silently
    if (!en_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      err_d   = 1'b0;
      deg_d   = deg_q;
    end

    if (rise_q) begin
      lost_cnt_d = '0;
    end else if ((state_q != ST_IDLE) && tick_i && (lost_cnt_q != LOST_C)) begin
      lost_cnt_d = lost_cnt_q + ONE_L;
    end

    if (valid_d) begin
      lost_d = 1'b0;
    end else if (lost_cnt_d == LOST_C) begin
      lost_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      width_q    <= '0;
      deg_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      lost_cnt_q <= '0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      deg_q      <= deg_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      lost_cnt_q <= lost_cnt_d;
      lost_q     <= lost_d;
    end
  end

  assign deg_o         = deg_q;
  assign deg_valid_o   = valid_q;
  assign pulse_err_o   = err_q;
  assign signal_lost_o = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_servo_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_servo_decoder
//  Description : Directed self-checking bench for pwm_servo_decoder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_servo_decoder;

  localparam int P   = 2;   // clk cycles per tick
  localparam int LAT = 5;   // SYNC_STAGES + 3

  logic       clk = 1'b0;
  logic       rst;
  logic       en_i;
  logic       tick_i;
  logic       pwm_in_i;
  logic [7:0] deg_o;
  logic       deg_valid_o;
  logic       pulse_err_o;
  logic       signal_lost_o;

  int n_chk  = 0;
  int n_pass = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;
  int tph     = 0;

  pwm_servo_decoder #(
    .CNTR_WIDTH (11),
    .MIN_TICKS  (50),
    .MAX_TICKS  (250),
    .LOST_TICKS (4096),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .tick_i       (tick_i),
    .pwm_in_i     (pwm_in_i),
    .deg_o        (deg_o),
    .deg_valid_o  (deg_valid_o),
    .pulse_err_o  (pulse_err_o),
    .signal_lost_o(signal_lost_o)
  );

  always #5 clk = ~clk;

  // Free-running tick strobe, one every P clocks
  initial begin
    tick_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_i = (tph == 0);
      tph    = (tph + 1) % P;
    end
  end

  // Strobe monitor
  always @(negedge clk) begin
    if (deg_valid_o) n_valid++;
    if (pulse_err_o) n_err++;
    if (deg_valid_o && pulse_err_o) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // High for exactly w ticks' worth of clocks, then watch 20 clocks after the fall
  task automatic pulse(input int w, output int lat, output int nv, output int ne,
                       output logic lost_at);
    int v0, e0;
    @(posedge clk);
    #1 pwm_in_i = 1'b1;
    repeat (w * P) @(posedge clk);
    #1 pwm_in_i = 1'b0;
    v0 = n_valid;
    e0 = n_err;
    lat = -1;
    lost_at = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #2;
      if (lat < 0 && (deg_valid_o || pulse_err_o)) begin
        lat = k;
        lost_at = signal_lost_o;
      end
    end
    @(negedge clk);
    nv = n_valid - v0;
    ne = n_err - e0;
  endtask

  logic last_lost_at;

  task automatic run_pulse(input string tag, input int w, input bit good, input int exp_deg);
    int lat, nv, ne;
    logic la;
    pulse(w, lat, nv, ne, la);
    chk({tag, "_valid"}, nv, good ? 1 : 0);
    chk({tag, "_err"}, ne, good ? 0 : 1);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_deg"}, deg_o, exp_deg);
    last_lost_at = la;
  endtask

  // Leave off so that the next pulse's edges land on (off=0) or off (off=1) ticks
  task automatic align(input int off);
    do begin
      @(posedge clk);
      #2;
    end while (!tick_i);
    repeat (off) @(posedge clk);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int v0, e0;
    rst = 1'b1;
    en_i = 1'b0;
    pwm_in_i = 1'b0;
    last_lost_at = 1'b0;
    idle_cycles(4);
    #2;
    chk("rst_deg", deg_o, 0);
    chk("rst_valid", deg_valid_o, 0);
    chk("rst_err", pulse_err_o, 0);
    chk("rst_lost", signal_lost_o, 0);
    #1 rst = 1'b0;
    en_i = 1'b1;
    idle_cycles(10);

    // Generator-shaped frames: high 140 ticks inside a 2048-tick frame
    for (int f = 0; f < 3; f++) begin
      run_pulse($sformatf("frame%0d", f), 140, 1'b1, 90);
      idle_cycles((2048 - 140) * P - 22);
    end

    // Boundaries and out-of-range widths
    run_pulse("w50", 50, 1'b1, 0);
    run_pulse("w250", 250, 1'b1, 200);
    run_pulse("w49", 49, 1'b0, 200);
    run_pulse("w251", 251, 1'b0, 200);
    run_pulse("w400", 400, 1'b0, 200);

    // Tick coincident with both edges, then deliberately off-tick
    align(0);
    run_pulse("coinc", 100, 1'b1, 50);
    align(1);
    run_pulse("offtick", 100, 1'b1, 50);
    run_pulse("w60", 60, 1'b1, 10);

    // Enable arrives mid-pulse: that partial pulse is ignored
    @(posedge clk);
    #1 en_i = 1'b0;
    pwm_in_i = 1'b1;
    idle_cycles(30 * P);
    #1 en_i = 1'b1;
    v0 = n_valid;
    e0 = n_err;
    idle_cycles(60 * P);
    #1 pwm_in_i = 1'b0;
    idle_cycles(30);
    @(negedge clk);
    chk("enmid_valid", n_valid - v0, 0);
    chk("enmid_err", n_err - e0, 0);
    run_pulse("w120", 120, 1'b1, 70);

    // Disable during HIGH
    @(posedge clk);
    #1 pwm_in_i = 1'b1;
    v0 = n_valid;
    e0 = n_err;
    idle_cycles(80 * P);
    #1 en_i = 1'b0;
    idle_cycles(4);
    #1 en_i = 1'b1;
    idle_cycles(40 * P);
    #1 pwm_in_i = 1'b0;
    idle_cycles(30);
    @(negedge clk);
    chk("enoff_valid", n_valid - v0, 0);
    chk("enoff_err", n_err - e0, 0);
    chk("enoff_deg", deg_o, 70);

    // Reset during HIGH
    @(posedge clk);
    #1 pwm_in_i = 1'b1;
    v0 = n_valid;
    e0 = n_err;
    idle_cycles(80 * P);
    #1 rst = 1'b1;
    idle_cycles(1);
    #1 rst = 1'b0;
    idle_cycles(40 * P);
    #1 pwm_in_i = 1'b0;
    idle_cycles(30);
    @(negedge clk);
    chk("rsthi_valid", n_valid - v0, 0);
    chk("rsthi_err", n_err - e0, 0);
    chk("rsthi_deg", deg_o, 0);
    run_pulse("resume", 180, 1'b1, 130);

    // Loss of signal: stuck low, then recovery
    idle_cycles((4096 - 300) * P);
    #2;
    chk("lost_before", signal_lost_o, 0);
    idle_cycles(200 * P);
    #1;
    chk("lost_after", signal_lost_o, 1);
    run_pulse("lost_err", 30, 1'b0, 130);
    chk("lost_kept_on_err", signal_lost_o, 1);
    run_pulse("lost_clr", 100, 1'b1, 50);
    chk("lost_at_valid", last_lost_at, 0);
    chk("lost_cleared", signal_lost_o, 0);

    chk("never_both", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
